// File: rtl/instr_trace_buffer_if.sv
// Trace drain port: ready/valid handshake carrying one 81-bit retirement record.
interface instr_trace_buffer_if;
    logic        TR_Valid;
    logic        TR_Ready;
    logic [80:0] TR_Data;

    modport master (output TR_Valid, output TR_Data, input TR_Ready);
    modport slave  (input TR_Valid, input TR_Data, output TR_Ready);
endinterface

// File: rtl/instr_trace_buffer.sv
// Retirement trace buffer: snapshots CPU state on each T-counter wrap to 0,
// queues records in a show-ahead FIFO, and keeps retire/drop stats plus a hang watchdog.
module instr_trace_buffer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic [2:0]                 T_in,
    input  logic                       BRA_in,
    input  logic [15:0]                IR_in,
    input  logic [7:0]                 RF_R1,
    input  logic [7:0]                 RF_R2,
    input  logic [7:0]                 RF_R3,
    input  logic [7:0]                 RF_R4,
    input  logic [7:0]                 ARF_PC,
    input  logic [7:0]                 ARF_SP,
    input  logic [7:0]                 ARF_AR,
    instr_trace_buffer_if.master       tr,
    output logic [$clog2(DEPTH):0]     TR_Count,
    output logic [15:0]                Retired,
    output logic [7:0]                 Dropped,
    output logic                       Hang
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2:0]    t_prev_q;
    logic [7:0]    cyc_q, cyc_d;
    logic [80:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   retired_q;
    logic [7:0]    dropped_q;
    logic [7:0]    wd_q, wd_d;
    logic          hang_q;

    logic        retire, full, valid, pop, push, drop;
    logic [80:0] rec;

    assign retire = Enable && (t_prev_q != 3'd0) && (T_in == 3'd0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign valid  = (cnt_q != '0);
    assign pop    = valid && tr.TR_Ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign push   = retire && (!full || pop);
    assign drop   = retire && full && !pop;

    assign rec = {cyc_q, BRA_in, IR_in, ARF_PC, ARF_AR, ARF_SP,
                  RF_R1, RF_R2, RF_R3, RF_R4};

    always_comb begin
        cyc_d = cyc_q;
        if (T_in == 3'd0)
            cyc_d = 8'd1;
        else if (cyc_q != 8'hFF)
            cyc_d = cyc_q + 8'd1;
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        wd_d = wd_q;
        if (!Enable || T_in == 3'd0)
            wd_d = 8'd0;
        else if (wd_q != 8'(TIMEOUT))
            wd_d = wd_q + 8'd1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            t_prev_q  <= '0;
            cyc_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            retired_q <= '0;
            dropped_q <= '0;
            wd_q      <= '0;
            hang_q    <= 1'b0;
        end else begin
            t_prev_q <= T_in;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (retire)
                retired_q <= retired_q + 16'd1;
            if (drop && dropped_q != 8'hFF)
                dropped_q <= dropped_q + 8'd1;
            if (wd_d == 8'(TIMEOUT))
                hang_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge Clock) begin
        if (push)
            mem_q[wr_ptr_q] <= rec;
    end

    assign tr.TR_Valid = valid;
    assign tr.TR_Data  = valid ? mem_q[rd_ptr_q] : '0;
    assign TR_Count    = cnt_q;
    assign Retired     = retired_q;
    assign Dropped     = dropped_q;
    assign Hang        = hang_q;
endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed bench for instr_trace_buffer: capture, overflow, full+pop, watchdog, enable, async reset.
module tb_instr_trace_buffer;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [2:0]  T_in;
    logic        BRA_in;
    logic [15:0] IR_in;
    logic [7:0]  RF_R1, RF_R2, RF_R3, RF_R4;
    logic [7:0]  ARF_PC, ARF_SP, ARF_AR;
    logic [3:0]  TR_Count;
    logic [15:0] Retired;
    logic [7:0]  Dropped;
    logic        Hang;

    int n_cmp = 0;
    int n_err = 0;

    instr_trace_buffer_if tr ();

    instr_trace_buffer #(.DEPTH(8), .TIMEOUT(16)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .T_in(T_in),
        .BRA_in(BRA_in), .IR_in(IR_in),
        .RF_R1(RF_R1), .RF_R2(RF_R2), .RF_R3(RF_R3), .RF_R4(RF_R4),
        .ARF_PC(ARF_PC), .ARF_SP(ARF_SP), .ARF_AR(ARF_AR),
        .tr(tr), .TR_Count(TR_Count), .Retired(Retired),
        .Dropped(Dropped), .Hang(Hang)
    );

    always #5 Clock = ~Clock;

    task automatic step(input logic [2:0] t);
        T_in = t;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; Enable = 1'b0; T_in = 3'd0; BRA_in = 1'b0;
        IR_in = '0; RF_R1 = '0; RF_R2 = '0; RF_R3 = '0; RF_R4 = '0;
        ARF_PC = '0; ARF_SP = '0; ARF_AR = '0; tr.TR_Ready = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
    endtask

    task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_valid", 81'(tr.TR_Valid), 81'(0));
        chk("rst_data",  tr.TR_Data, 81'(0));
        chk("rst_count", 81'(TR_Count), 81'(0));
        chk("rst_retired", 81'(Retired), 81'(0));
        chk("rst_dropped", 81'(Dropped), 81'(0));
        chk("rst_hang", 81'(Hang), 81'(0));
    endtask

    task automatic test_capture();
        do_reset();
        Enable = 1'b1;
        step(3'd0); step(3'd1); step(3'd2);
        IR_in = 16'h1234; ARF_PC = 8'h05; RF_R1 = 8'hAA;
        chk("cap_not_yet", 81'(tr.TR_Valid), 81'(0));
        step(3'd0);
        chk("cap_valid", 81'(tr.TR_Valid), 81'(1));
        chk("cap_data", tr.TR_Data, {8'd3, 1'b0, 16'h1234, 8'h05, 8'h00, 8'h00, 8'hAA, 24'h0});
        chk("cap_retired", 81'(Retired), 81'(1));
        chk("cap_count", 81'(TR_Count), 81'(1));
        IR_in = '0; ARF_PC = '0; RF_R1 = '0;
        tr.TR_Ready = 1'b1;
        step(3'd1);
        tr.TR_Ready = 1'b0;
        chk("cap_pop_valid", 81'(tr.TR_Valid), 81'(0));
        chk("cap_pop_data", tr.TR_Data, 81'(0));
        chk("cap_pop_count", 81'(TR_Count), 81'(0));
    endtask

    task automatic test_overflow();
        logic [7:0] c;
        do_reset();
        Enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(3'd1);
            IR_in = 16'(k); ARF_PC = 8'(k);
            step(3'd0);
        end
        chk("ovf_count", 81'(TR_Count), 81'(8));
        chk("ovf_dropped", 81'(Dropped), 81'(2));
        chk("ovf_retired", 81'(Retired), 81'(10));
        Enable = 1'b0; tr.TR_Ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            c = (k == 0) ? 8'd1 : 8'd2;
            chk("ovf_drain_valid", 81'(tr.TR_Valid), 81'(1));
            chk("ovf_drain_data", tr.TR_Data, {c, 1'b0, 16'(k), 8'(k), 48'h0});
            step(3'd0);
        end
        tr.TR_Ready = 1'b0;
        chk("ovf_empty_valid", 81'(tr.TR_Valid), 81'(0));
        chk("ovf_empty_count", 81'(TR_Count), 81'(0));
        chk("ovf_dropped_hold", 81'(Dropped), 81'(2));
    endtask

    task automatic test_back_to_back_full_pop();
        do_reset();
        Enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(3'd1);
            IR_in = 16'h0100 + 16'(k);
            step(3'd0);
        end
        chk("fp_full", 81'(TR_Count), 81'(8));
        step(3'd1);
        IR_in = 16'h0200; tr.TR_Ready = 1'b1;
        step(3'd0);
        tr.TR_Ready = 1'b0;
        chk("fp_count", 81'(TR_Count), 81'(8));
        chk("fp_dropped", 81'(Dropped), 81'(0));
        chk("fp_retired", 81'(Retired), 81'(9));
        Enable = 1'b0; tr.TR_Ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("fp_order", 81'(tr.TR_Data[71:56]),
                81'((k < 7) ? (16'h0101 + 16'(k)) : 16'h0200));
            step(3'd0);
        end
        tr.TR_Ready = 1'b0;
        chk("fp_empty", 81'(tr.TR_Valid), 81'(0));
    endtask

    task automatic test_hang();
        do_reset();
        Enable = 1'b1;
        for (int k = 0; k < 15; k++) step(3'd3);
        chk("hang_before", 81'(Hang), 81'(0));
        step(3'd3);
        chk("hang_set", 81'(Hang), 81'(1));
        step(3'd0); step(3'd0);
        chk("hang_sticky", 81'(Hang), 81'(1));
        #2 Reset = 1'b0;
        #1;
        chk("hang_cleared", 81'(Hang), 81'(0));
        Reset = 1'b1;
    endtask

    task automatic test_enable();
        do_reset();
        step(3'd0); step(3'd1); step(3'd2); step(3'd0);
        chk("en_no_rec", 81'(tr.TR_Valid), 81'(0));
        chk("en_no_retire", 81'(Retired), 81'(0));
        Enable = 1'b1;
        step(3'd0); step(3'd1);
        IR_in = 16'hBEEF;
        step(3'd0);
        chk("en_rec_valid", 81'(tr.TR_Valid), 81'(1));
        chk("en_rec_data", tr.TR_Data, {8'd2, 1'b0, 16'hBEEF, 56'h0});
        chk("en_retired", 81'(Retired), 81'(1));
    endtask

    task automatic test_async_reset();
        do_reset();
        Enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(3'd1); step(3'd0);
        end
        chk("ar_count4", 81'(TR_Count), 81'(4));
        tr.TR_Ready = 1'b1;
        step(3'd1);
        chk("ar_count3", 81'(TR_Count), 81'(3));
        #2 Reset = 1'b0;
        #1;
        chk("ar_valid", 81'(tr.TR_Valid), 81'(0));
        chk("ar_count", 81'(TR_Count), 81'(0));
        chk("ar_retired", 81'(Retired), 81'(0));
        chk("ar_dropped", 81'(Dropped), 81'(0));
        tr.TR_Ready = 1'b0;
        Reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_overflow();
        test_back_to_back_full_pop();
        test_hang();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
